// File: rtl/gyro_integrator.sv
// gyro_integrator: bias-calibrated three-axis gyro rate integrator.
// Averages the first 2^CAL_LOG2 samples per axis into a zero-rate bias.
// It then adds bias-corrected rates into wrapping angle accumulators,
// using one adder that is shared across the axes in the order X, Y, Z.
// Optional build macro: GYRO_INTEG_DEADBAND_EN. When it is defined,
// corrected rates with magnitude <= DEADBAND are not integrated.
module gyro_integrator #(
  parameter int CAL_LOG2 = 6,
  parameter int ANGLE_W  = 32,
  parameter int DEADBAND = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sample_valid,
  input  logic signed [15:0]        gyro_x,
  input  logic signed [15:0]        gyro_y,
  input  logic signed [15:0]        gyro_z,
  input  logic                      recal,
  input  logic                      zero_angles,
  output logic signed [ANGLE_W-1:0] angle_x,
  output logic signed [ANGLE_W-1:0] angle_y,
  output logic signed [ANGLE_W-1:0] angle_z,
  output logic                      angle_valid,
  output logic                      calibrated,
  output logic                      overrun
);

  localparam int SUM_W = 16 + CAL_LOG2;
  localparam int CNT_W = CAL_LOG2 + 1;
  localparam logic [CNT_W-1:0] CAL_N = {1'b1, {CAL_LOG2{1'b0}}};

  typedef enum logic [2:0] {
    CAL_WAIT, CAL_ACC, CAL_DONE, RUN_WAIT, UPD_X, UPD_Y, UPD_Z, EMIT
  } state_e;

  state_e                    state_q, state_d;
  logic signed [15:0]        samp_x_q, samp_y_q, samp_z_q, samp_x_d, samp_y_d, samp_z_d;
  logic signed [15:0]        bias_x_q, bias_y_q, bias_z_q, bias_x_d, bias_y_d, bias_z_d;
  logic signed [SUM_W-1:0]   sum_x_q, sum_y_q, sum_z_q, sum_x_d, sum_y_d, sum_z_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic signed [ANGLE_W-1:0] angle_x_q, angle_y_q, angle_z_q, angle_x_d, angle_y_d, angle_z_d;
  logic                      angle_valid_q, angle_valid_d;
  logic                      calibrated_q, calibrated_d;
  logic                      overrun_q, overrun_d;

  logic signed [15:0]        samp_sel_s, bias_sel_s;
  logic signed [ANGLE_W-1:0] angle_sel_s, addend_s, adder_s;
  logic signed [16:0]        rate_s;
  logic                      busy_s;

  // Shared adder: pick the axis being updated and add its corrected rate.
  always_comb begin
    case (state_q)
      UPD_X: begin
        samp_sel_s  = samp_x_q;
        bias_sel_s  = bias_x_q;
        angle_sel_s = angle_x_q;
      end
      UPD_Y: begin
        samp_sel_s  = samp_y_q;
        bias_sel_s  = bias_y_q;
        angle_sel_s = angle_y_q;
      end
      default: begin
        samp_sel_s  = samp_z_q;
        bias_sel_s  = bias_z_q;
        angle_sel_s = angle_z_q;
      end
    endcase
    rate_s   = {samp_sel_s[15], samp_sel_s} - {bias_sel_s[15], bias_sel_s};
    addend_s = {{(ANGLE_W-17){rate_s[16]}}, rate_s};
`ifdef GYRO_INTEG_DEADBAND_EN
    if ((rate_s[16] ? (17'd0 - rate_s) : rate_s) <= 17'(DEADBAND)) begin
      addend_s = {ANGLE_W{1'b0}};
    end else begin
      addend_s = {{(ANGLE_W-17){rate_s[16]}}, rate_s};
    end
`endif
    adder_s  = angle_sel_s + addend_s;
  end

  // Next-state logic: calibration, run-phase sequencing, clears and overrun.
  always_comb begin
    state_d       = state_q;
    samp_x_d      = samp_x_q;
    samp_y_d      = samp_y_q;
    samp_z_d      = samp_z_q;
    bias_x_d      = bias_x_q;
    bias_y_d      = bias_y_q;
    bias_z_d      = bias_z_q;
    sum_x_d       = sum_x_q;
    sum_y_d       = sum_y_q;
    sum_z_d       = sum_z_q;
    cnt_d         = cnt_q;
    angle_x_d     = angle_x_q;
    angle_y_d     = angle_y_q;
    angle_z_d     = angle_z_q;
    angle_valid_d = 1'b0;
    calibrated_d  = calibrated_q;
    overrun_d     = overrun_q;
    busy_s        = (state_q != CAL_WAIT) && (state_q != RUN_WAIT);

    if (recal) begin
      // Full restart; a sample in this same cycle is simply ignored.
      state_d      = CAL_WAIT;
      angle_x_d    = {ANGLE_W{1'b0}};
      angle_y_d    = {ANGLE_W{1'b0}};
      angle_z_d    = {ANGLE_W{1'b0}};
      sum_x_d      = {SUM_W{1'b0}};
      sum_y_d      = {SUM_W{1'b0}};
      sum_z_d      = {SUM_W{1'b0}};
      cnt_d        = {CNT_W{1'b0}};
      calibrated_d = 1'b0;
      overrun_d    = 1'b0;
    end else begin
      if (sample_valid && busy_s) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
      if (zero_angles) begin
        angle_x_d = {ANGLE_W{1'b0}};
        angle_y_d = {ANGLE_W{1'b0}};
        angle_z_d = {ANGLE_W{1'b0}};
      end else begin
        angle_x_d = angle_x_q;
      end
      case (state_q)
        CAL_WAIT, RUN_WAIT: begin
          if (sample_valid) begin
            samp_x_d = gyro_x;
            samp_y_d = gyro_y;
            samp_z_d = gyro_z;
            state_d  = (state_q == CAL_WAIT) ? CAL_ACC : UPD_X;
          end else begin
            state_d  = state_q;
          end
        end
        CAL_ACC: begin
          sum_x_d = sum_x_q + {{CAL_LOG2{samp_x_q[15]}}, samp_x_q};
          sum_y_d = sum_y_q + {{CAL_LOG2{samp_y_q[15]}}, samp_y_q};
          sum_z_d = sum_z_q + {{CAL_LOG2{samp_z_q[15]}}, samp_z_q};
          cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
          state_d = (cnt_d == CAL_N) ? CAL_DONE : CAL_WAIT;
        end
        CAL_DONE: begin
          // Arithmetic shift right then truncate == this slice (floor divide).
          bias_x_d     = sum_x_q[CAL_LOG2 +: 16];
          bias_y_d     = sum_y_q[CAL_LOG2 +: 16];
          bias_z_d     = sum_z_q[CAL_LOG2 +: 16];
          calibrated_d = 1'b1;
          state_d      = RUN_WAIT;
        end
        UPD_X, UPD_Y, UPD_Z: begin
          if (zero_angles) begin
            state_d = RUN_WAIT;
          end else if (state_q == UPD_X) begin
            angle_x_d = adder_s;
            state_d   = UPD_Y;
          end else if (state_q == UPD_Y) begin
            angle_y_d = adder_s;
            state_d   = UPD_Z;
          end else begin
            angle_z_d     = adder_s;
            angle_valid_d = 1'b1;
            state_d       = EMIT;
          end
        end
        EMIT: begin
          state_d = RUN_WAIT;
        end
        default: begin
          state_d = CAL_WAIT;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CAL_WAIT;
      samp_x_q      <= 16'sd0;
      samp_y_q      <= 16'sd0;
      samp_z_q      <= 16'sd0;
      bias_x_q      <= 16'sd0;
      bias_y_q      <= 16'sd0;
      bias_z_q      <= 16'sd0;
      sum_x_q       <= {SUM_W{1'b0}};
      sum_y_q       <= {SUM_W{1'b0}};
      sum_z_q       <= {SUM_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      angle_x_q     <= {ANGLE_W{1'b0}};
      angle_y_q     <= {ANGLE_W{1'b0}};
      angle_z_q     <= {ANGLE_W{1'b0}};
      angle_valid_q <= 1'b0;
      calibrated_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_x_q      <= samp_x_d;
      samp_y_q      <= samp_y_d;
      samp_z_q      <= samp_z_d;
      bias_x_q      <= bias_x_d;
      bias_y_q      <= bias_y_d;
      bias_z_q      <= bias_z_d;
      sum_x_q       <= sum_x_d;
      sum_y_q       <= sum_y_d;
      sum_z_q       <= sum_z_d;
      cnt_q         <= cnt_d;
      angle_x_q     <= angle_x_d;
      angle_y_q     <= angle_y_d;
      angle_z_q     <= angle_z_d;
      angle_valid_q <= angle_valid_d;
      calibrated_q  <= calibrated_d;
      overrun_q     <= overrun_d;
    end
  end

  assign angle_x     = angle_x_q;
  assign angle_y     = angle_y_q;
  assign angle_z     = angle_z_q;
  assign angle_valid = angle_valid_q;
  assign calibrated  = calibrated_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/gyro_integrator.md
Name: gyro_integrator

Overview:
- Sits directly downstream of the MPU6050 gyro read controller; consumes its per-axis signed 16-bit rate words and its completion pulse.
- Estimates a per-axis zero-rate bias by averaging the first 2^CAL_LOG2 samples.
- Then integrates bias-corrected rates into three wrapping angle accumulators that drive the rotation/display logic.
- Uses one shared adder, time-multiplexed X -> Y -> Z.

Parameters:
- CAL_LOG2, 6: log2 of the number of calibration samples averaged for bias.
- ANGLE_W, 32: width of each signed angle accumulator.
- DEADBAND, 4: magnitude threshold in LSB; used only when GYRO_INTEG_DEADBAND_EN is defined.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle pulse; gyro_x/y/z valid this cycle
- gyro_x  in  16  signed X rate
- gyro_y  in  16  signed Y rate
- gyro_z  in  16  signed Z rate
- recal  in  1  pulse; restart calibration and clear angles
- zero_angles  in  1  pulse; clear angles, keep bias
- angle_x  out  ANGLE_W  signed integrated X angle
- angle_y  out  ANGLE_W  signed integrated Y angle
- angle_z  out  ANGLE_W  signed integrated Z angle
- angle_valid  out  1  one-cycle pulse; angles updated
- calibrated  out  1  high once bias is valid
- overrun  out  1  sticky; sample arrived while busy

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (async, rst_n=0):
  - angles = 0, biases = 0, sums = 0, cal count = 0
  - angle_valid = 0, calibrated = 0, overrun = 0
  - state = CAL_WAIT
- States:
  - CAL_WAIT, CAL_ACC: calibration phase.
  - CAL_DONE: bias computation.
  - RUN_WAIT, UPD_X, UPD_Y, UPD_Z: run phase.
  - EMIT: completion pulse.
- Calibration:
  - CAL_WAIT: on sample_valid, latch the three samples -> CAL_ACC.
  - CAL_ACC (1 cycle): each sum (16+CAL_LOG2 bits, signed) += sign-extended latched sample; count++.
  - If count reaches 2^CAL_LOG2 -> CAL_DONE, else -> CAL_WAIT.
  - CAL_DONE (1 cycle): bias_a = sum_a >>> CAL_LOG2 (arithmetic, floor); calibrated <= 1 -> RUN_WAIT.
  - No angle_valid during calibration.
- Run:
  - RUN_WAIT: on sample_valid, latch samples -> UPD_X.
  - UPD_X / UPD_Y / UPD_Z, one cycle each, per axis a:
    - rate_a = sample_a - bias_a, computed in 17-bit signed.
    - rate_a is sign-extended to ANGLE_W.
    - angle_a <= angle_a + rate_a, modulo 2^ANGLE_W (two's-complement wrap, no saturation).
  - EMIT: angle_valid = 1 for exactly one cycle -> RUN_WAIT.
  - Latency: sample_valid at cycle t -> angle_valid high at t+4; all three angles stable from t+4.
- Busy/overrun:
  - sample_valid in any state other than CAL_WAIT or RUN_WAIT is dropped and sets overrun.
  - overrun clears only on reset or recal.
- recal (any state):
  - Clears angles, sums, count, calibrated and overrun; -> CAL_WAIT next cycle.
  - An in-flight update is aborted with no angle_valid.
  - recal wins over sample_valid in the same cycle; that sample is discarded and does not set overrun.
- zero_angles (any state):
  - Clears all three angles; bias is retained.
  - If asserted during UPD_*/EMIT, the update is aborted, no angle_valid, -> RUN_WAIT.
  - In calibration states it clears angles only; calibration continues.
  - recal has priority when both are asserted.
- Output stability: angles change only in UPD_* or on clear; angle_* are registered outputs.

Optional Feature:
- Macro: GYRO_INTEG_DEADBAND_EN.
- Defined: in UPD_*, if |rate_a| <= DEADBAND, the added value is 0 and the angle is unchanged; timing is otherwise identical.
- Undefined: every rate is integrated; the DEADBAND parameter is ignored.

Test Plan:
- CAL_LOG2=2; X samples 10,12,14,16 -> calibrated rises 1 cycle after 4th sample's CAL_ACC; bias_x=13; no angle_valid. Next sample x=113 -> angle_x=100 at t+4, angle_valid pulses once.
- Negative bias: X samples -3,-3,-3,-2 (sum -11) -> bias_x=-3 (floor). Then x=-3 -> angle_x unchanged at 0, angle_valid still pulses.
- ANGLE_W=20, bias 0, 17 samples of x=32767 -> angle_x = -491537 (wraps past 524287); no saturation.
- sample_valid at t and again at t+2 -> second sample dropped, overrun=1, single angle_valid at t+4; recal clears overrun and calibrated.
- zero_angles asserted in UPD_Y -> all angles 0, no angle_valid, next sample integrates from 0. recal and sample_valid in the same cycle -> state CAL_WAIT, count 0, overrun 0.
- With GYRO_INTEG_DEADBAND_EN, DEADBAND=4, bias 0: x=4 -> angle_x unchanged; x=5 -> +5; x=-4 -> unchanged. Without the macro, x=4 -> +4. rst_n low mid-UPD_X -> all outputs 0 immediately, asynchronously.
